// File: rtl/lidar_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package    : lidar_ctrl_pkg
// Description: Shared types and constants for the LiDAR scan controller:
//              controller state encoding, sensor command/response bytes,
//              response descriptor length and a small saturating helper.
// Build macro: LIDAR_PKT_COUNT_EN (consumed by lidar_scan_ctrl)
// Revision   : 1.0 - initial release
// ============================================================================
package lidar_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    SEND_START0 = 4'd1,
    SEND_START1 = 4'd2,
    WAIT_RESP   = 4'd3,
    SCANNING    = 4'd4,
    SEND_STOP0  = 4'd5,
    SEND_STOP1  = 4'd6,
    DRAIN       = 4'd7,
    ERROR       = 4'd8
  } ctrl_state_t;

  localparam logic [7:0] CMD_SYNC   = 8'hA5;
  localparam logic [7:0] CMD_START  = 8'h60;
  localparam logic [7:0] CMD_STOP   = 8'h65;
  localparam logic [7:0] RESP_SYNC2 = 8'h5A;

  // Start response descriptor length in bytes.
  localparam int RESP_LEN = 7;

  // Two-bit increment that sticks at 3.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lidar_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface  : lidar_scan_ctrl_if
// Description: Groups the UART TX/RX byte streams and the packet parser
//              handshake seen by the scan controller.
// Ports      : tx_data_out/tx_valid_out/tx_ready_in - command bytes to UART TX
//              rx_data_in/rx_valid_in               - bytes from UART RX
//              packet_done_in/parser_en_out         - parser pulse / enable
// Modports   : master = controller side, slave = peripheral side
// Revision   : 1.0 - initial release
// ============================================================================
interface lidar_scan_ctrl_if;

  logic [7:0] tx_data_out;
  logic       tx_valid_out;
  logic       tx_ready_in;
  logic [7:0] rx_data_in;
  logic       rx_valid_in;
  logic       packet_done_in;
  logic       parser_en_out;

  modport master (
    output tx_data_out, tx_valid_out, parser_en_out,
    input  tx_ready_in, rx_data_in, rx_valid_in, packet_done_in
  );

  modport slave (
    input  tx_data_out, tx_valid_out, parser_en_out,
    output tx_ready_in, rx_data_in, rx_valid_in, packet_done_in
  );

endinterface
`default_nettype wire

// File: rtl/lidar_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module     : lidar_timeout_timer
// Description: Cycle counter that pulses expired_out for one cycle when it
//              has counted LIMIT enabled cycles since the last clear.
// Ports      : clk_in, rst_in   - clock, synchronous active-high reset
//              clear_in         - restart count from zero (wins over enable)
//              enable_in        - count this cycle
//              expired_out      - single-cycle expiry pulse
// Revision   : 1.0 - initial release
// ============================================================================
module lidar_timeout_timer #(
  parameter int LIMIT = 100
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  input  logic enable_in,
  output logic expired_out
);

  localparam int         W    = $clog2(LIMIT) + 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q, count_d;

  assign expired_out = enable_in && !clear_in && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_in) begin
      count_d = '0;
    end else if (enable_in) begin
      // Wrap on expiry so the pulse cannot repeat on the next cycle.
      count_d = expired_out ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule
`default_nettype wire

// File: rtl/lidar_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : lidar_scan_ctrl
// Description: Sequences LiDAR start/stop commands over UART TX, validates
//              the start response descriptor, enables the packet parser and
//              supervises packet flow with a retrying watchdog.
// Ports      : clk_in, rst_in          - clock, synchronous active-high reset
//              start_scan_in           - scan start request pulse
//              stop_scan_in            - scan stop request pulse
//              bus (master)            - UART TX/RX + parser handshake
//              scanning_out, error_out - status
//              retry_count_out         - consecutive retry count (sat. at 3)
//              pkt_count_out           - packets seen while scanning
// Build macro: LIDAR_PKT_COUNT_EN - enables the saturating packet counter;
//              otherwise pkt_count_out is tied to zero.
// Revision   : 1.0 - initial release
// ============================================================================
module lidar_scan_ctrl
  import lidar_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10_000_000,
  parameter int MAX_RETRIES    = 3,
  parameter int DRAIN_CYCLES   = 1_000_000
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_scan_in,
  input  logic                stop_scan_in,
  lidar_scan_ctrl_if.master   bus,
  output logic                scanning_out,
  output logic                error_out,
  output logic [1:0]          retry_count_out,
  output logic [15:0]         pkt_count_out
);

  ctrl_state_t state_q, state_d;
  logic [1:0]  retry_q, retry_d;
  logic [2:0]  idx_q, idx_d;
  logic        restart_q, restart_d;
  logic        stop_pend_q, stop_pend_d;

  logic in_send, tx_fire, in_wd, resp_last, wd_clear, wd_expired, dr_expired;

  assign in_send   = (state_q == SEND_START0) || (state_q == SEND_START1) ||
                     (state_q == SEND_STOP0)  || (state_q == SEND_STOP1);
  assign tx_fire   = in_send && bus.tx_ready_in;
  assign in_wd     = (state_q == WAIT_RESP) || (state_q == SCANNING);
  assign resp_last = (state_q == WAIT_RESP) && bus.rx_valid_in &&
                     (idx_q == 3'(RESP_LEN - 1));
  // Outside the supervised states the watchdog is held at zero, so every
  // entry into WAIT_RESP or SCANNING starts from a clean count.
  assign wd_clear  = !in_wd || resp_last ||
                     ((state_q == SCANNING) && bus.packet_done_in);

  lidar_timeout_timer #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_in    (wd_clear),
    .enable_in   (in_wd),
    .expired_out (wd_expired)
  );

  lidar_timeout_timer #(.LIMIT(DRAIN_CYCLES)) u_drain (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_in    (state_q != DRAIN),
    .enable_in   (state_q == DRAIN),
    .expired_out (dr_expired)
  );

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      retry_q     <= 2'd0;
      idx_q       <= 3'd0;
      restart_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      idx_q       <= idx_d;
      restart_q   <= restart_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    idx_d       = (state_q == WAIT_RESP) ? idx_q : 3'd0;
    restart_d   = restart_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start_scan_in && !stop_scan_in) begin
          state_d   = SEND_START0;
          retry_d   = 2'd0;
          restart_d = 1'b0;
        end
      end
      SEND_START0, SEND_START1: begin
        if (stop_scan_in) begin
          stop_pend_d = 1'b1;
          restart_d   = 1'b0;
        end
        // The byte on the wire always completes before redirecting.
        if (tx_fire) begin
          if (stop_scan_in || stop_pend_q) state_d = SEND_STOP0;
          else if (state_q == SEND_START0) state_d = SEND_START1;
          else                             state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (stop_scan_in) begin
          restart_d = 1'b0;
          state_d   = SEND_STOP0;
        end else if (wd_expired) begin
          if (int'(retry_q) < MAX_RETRIES) begin
            retry_d = sat_inc2(retry_q);
            state_d = SEND_START0;
          end else begin
            state_d = ERROR;
          end
        end else if (bus.rx_valid_in) begin
          if (resp_last) begin
            state_d = SCANNING;
            retry_d = 2'd0;
          end else if (idx_q == 3'd0 || idx_q == 3'd1) begin
            // A byte that breaks the sync pair is re-tried as byte 0.
            if (idx_q == 3'd1 && bus.rx_data_in == RESP_SYNC2) idx_d = 3'd2;
            else if (bus.rx_data_in == CMD_SYNC)               idx_d = 3'd1;
            else                                               idx_d = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      SCANNING: begin
        if (stop_scan_in) begin
          restart_d = 1'b0;
          state_d   = SEND_STOP0;
        end else if (wd_expired) begin
          if (int'(retry_q) < MAX_RETRIES) begin
            retry_d   = sat_inc2(retry_q);
            restart_d = 1'b1;
            state_d   = SEND_STOP0;
          end else begin
            state_d = ERROR;
          end
        end
      end
      SEND_STOP0: begin
        stop_pend_d = 1'b0;
        if (tx_fire) state_d = SEND_STOP1;
      end
      SEND_STOP1: begin
        if (tx_fire) state_d = DRAIN;
      end
      DRAIN: begin
        if (dr_expired) begin
          state_d   = restart_q ? SEND_START0 : IDLE;
          restart_d = 1'b0;
        end
      end
      ERROR: begin
        if (stop_scan_in) begin
          restart_d = 1'b0;
          state_d   = IDLE;
        end else if (start_scan_in) begin
          retry_d = 2'd0;
          state_d = SEND_START0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.tx_valid_out  = in_send;
    bus.tx_data_out   = 8'h00;
    bus.parser_en_out = (state_q == SCANNING);
    scanning_out      = (state_q == SCANNING);
    error_out         = (state_q == ERROR);
    retry_count_out   = retry_q;
    case (state_q)
      SEND_START0, SEND_STOP0: bus.tx_data_out = CMD_SYNC;
      SEND_START1:             bus.tx_data_out = CMD_START;
      SEND_STOP1:              bus.tx_data_out = CMD_STOP;
      default:                 bus.tx_data_out = 8'h00;
    endcase
  end

`ifdef LIDAR_PKT_COUNT_EN
  logic [15:0] pkt_q, pkt_d;
  logic        pkt_clr;

  // Only user-initiated starts reset the count; watchdog restarts keep it.
  assign pkt_clr = ((state_q == IDLE) || (state_q == ERROR)) &&
                   start_scan_in && !stop_scan_in;

  always_comb begin
    pkt_d = pkt_q;
    if (pkt_clr)
      pkt_d = 16'h0000;
    else if ((state_q == SCANNING) && bus.packet_done_in && (pkt_q != 16'hFFFF))
      pkt_d = pkt_q + 16'h0001;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) pkt_q <= 16'h0000;
    else        pkt_q <= pkt_d;
  end

  assign pkt_count_out = pkt_q;
`else
  assign pkt_count_out = 16'h0000;
`endif

endmodule
`default_nettype wire
